// File: rtl/keypad_scanner.sv
// Keypad front end for the safe controller: scans a 4x3 matrix, classifies each
// full scan and debounces across scans into a single key_valid strobe per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       init,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_SINGLE = 2'd1;
    localparam logic [1:0] RES_MULTI  = 2'd2;

    logic [2:0]         col_m;
    logic [2:0]         col_s;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         row_idx;
    logic               sample_edge;
    logic               frame_end;

    logic [1:0]         col_ones;
    logic               row_single;
    logic               row_multi;
    logic [3:0]         row_code;

    logic [1:0]         acc_rows;
    logic               acc_multi;
    logic [3:0]         acc_code;
    logic [1:0]         rows_next;
    logic               multi_next;
    logic [3:0]         code_next;
    logic [1:0]         frame_result;

    logic [1:0]         state;
    logic [3:0]         cand;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [2:0] c);
        logic [1:0] j;
        logic [3:0] code;
        if (c[0])
            j = 2'd0;
        else if (c[1])
            j = 2'd1;
        else
            j = 2'd2;
        case ({r, j})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b11_00: code = 4'd10;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd11;
            default:  code = 4'd15;
        endcase
        return code;
    endfunction

    // Columns are asynchronous to clk, so they pass through two flops first.
    always_ff @(posedge clk) begin
        if (init) begin
            col_m <= 3'b000;
            col_s <= 3'b000;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    assign sample_edge = (dwell == DWELL_LAST);
    assign frame_end   = sample_edge && (row_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (init) begin
            dwell   <= '0;
            row_idx <= 2'd0;
            row     <= 4'b0001;
        end else if (sample_edge) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= {row[2:0], row[3]};
        end else begin
            dwell   <= dwell + DWELL_W'(1);
        end
    end

    assign col_ones   = {1'b0, col_s[0]} + {1'b0, col_s[1]} + {1'b0, col_s[2]};
    assign row_single = (col_ones == 2'd1);
    assign row_multi  = (col_ones >= 2'd2);
    assign row_code   = key_lookup(row_idx, col_s);

    // The accumulator view including the current sample; rows_next saturates at 2,
    // which is all the frame classification needs to tell one candidate from many.
    always_comb begin
        rows_next  = acc_rows;
        multi_next = acc_multi | row_multi;
        code_next  = acc_code;
        if (row_single) begin
            code_next = row_code;
            if (acc_rows != 2'd2)
                rows_next = acc_rows + 2'd1;
        end
    end

    always_comb begin
        frame_result = RES_MULTI;
        if (rows_next == 2'd0 && !multi_next)
            frame_result = RES_NONE;
        else if (rows_next == 2'd1 && !multi_next)
            frame_result = RES_SINGLE;
    end

    always_ff @(posedge clk) begin
        if (init || frame_end) begin
            acc_rows  <= 2'd0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (sample_edge) begin
            acc_rows  <= rows_next;
            acc_multi <= multi_next;
            acc_code  <= code_next;
        end
    end

    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;

    // Debounce runs only at frame ends; a press must be fully released before
    // another key can be accepted.
    always_ff @(posedge clk) begin
        if (init) begin
            state     <= ST_IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'd15;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (frame_result == RES_SINGLE) begin
                            cand  <= code_next;
                            cnt   <= CNT_ONE;
                            state <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (frame_result == RES_SINGLE) begin
                            if (code_next == cand) begin
                                cnt <= cnt_inc;
                                if (cnt_inc == CNT_DONE) begin
                                    state     <= ST_PRESSED;
                                    key_code  <= cand;
                                    key_valid <= 1'b1;
                                    key_held  <= 1'b1;
                                end
                            end else begin
                                cand <= code_next;
                                cnt  <= CNT_ONE;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (frame_result == RES_NONE) begin
                            cnt   <= CNT_ONE;
                            state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (frame_result == RES_NONE) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                            end
                        end else begin
                            state <= ST_PRESSED;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 keypad driving the
// columns from the scanned rows.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 8;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME          = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        init;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [11:0] key_mask;

    int checks      = 0;
    int failures    = 0;
    int strobes     = 0;
    int wide_pulses = 0;
    int base;
    logic valid_prev = 1'b0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .init      (init),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // key_mask bit r*3+c models the switch at row r, column c
    always_comb begin
        col = 3'b000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (row[r] && key_mask[r*3+c])
                    col[c] = 1'b1;
    end

    always @(posedge clk) begin
        #2;
        if (key_valid) begin
            strobes++;
            if (valid_prev)
                wide_pulses++;
        end
        valid_prev = key_valid;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFrames(input int n);
        waitCycles(n * FRAME);
    endtask

    task automatic applyStimulus(input int code, input logic down);
        int idx;
        if (code == 0)
            idx = 10;
        else if (code <= 9)
            idx = code - 1;
        else if (code == 10)
            idx = 9;
        else
            idx = 11;
        key_mask[idx] = down;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        init     = 1'b1;
        key_mask = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_row", 32'(row), 32'd1);
        checkOutput("rst_code", 32'(key_code), 32'd15);
        checkOutput("rst_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_held", 32'(key_held), 32'd0);
        init = 1'b0;

        waitCycles(7);
        checkOutput("row_c7", 32'(row), 32'd1);
        waitCycles(1);
        checkOutput("row_c8", 32'(row), 32'd2);
        waitCycles(16);
        checkOutput("row_c24", 32'(row), 32'd8);
        waitCycles(8);
        checkOutput("row_c32", 32'(row), 32'd1);

        $display("[TB] press 5 for 6 frames");
        applyStimulus(5, 1'b1);
        waitFrames(2);
        checkOutput("k5_early_strobes", 32'(strobes), 32'd0);
        checkOutput("k5_early_held", 32'(key_held), 32'd0);
        waitFrames(1);
        checkOutput("k5_valid", 32'(key_valid), 32'd1);
        checkOutput("k5_code", 32'(key_code), 32'd5);
        checkOutput("k5_held", 32'(key_held), 32'd1);
        checkOutput("k5_strobes", 32'(strobes), 32'd1);
        waitCycles(1);
        checkOutput("k5_valid_drop", 32'(key_valid), 32'd0);
        waitCycles(3 * FRAME - 1);
        checkOutput("k5_hold_held", 32'(key_held), 32'd1);
        checkOutput("k5_hold_strobes", 32'(strobes), 32'd1);
        applyStimulus(5, 1'b0);
        waitFrames(2);
        checkOutput("k5_rel2_held", 32'(key_held), 32'd1);
        waitFrames(1);
        checkOutput("k5_rel3_held", 32'(key_held), 32'd0);
        checkOutput("k5_rel_code", 32'(key_code), 32'd5);
        checkOutput("k5_rel_strobes", 32'(strobes), 32'd1);

        $display("[TB] bouncing 9");
        base = strobes;
        applyStimulus(9, 1'b1);
        waitFrames(2);
        applyStimulus(9, 1'b0);
        waitFrames(1);
        applyStimulus(9, 1'b1);
        waitFrames(2);
        checkOutput("k9_bounce_strobes", 32'(strobes), 32'(base));
        waitFrames(1);
        checkOutput("k9_valid", 32'(key_valid), 32'd1);
        checkOutput("k9_code", 32'(key_code), 32'd9);
        checkOutput("k9_strobes", 32'(strobes), 32'(base + 1));
        applyStimulus(9, 1'b0);
        waitFrames(3);
        checkOutput("k9_rel_held", 32'(key_held), 32'd0);

        $display("[TB] 1 and 0 together");
        base = strobes;
        applyStimulus(1, 1'b1);
        applyStimulus(0, 1'b1);
        waitFrames(5);
        checkOutput("multi_strobes", 32'(strobes), 32'(base));
        checkOutput("multi_held", 32'(key_held), 32'd0);
        key_mask = 12'h000;
        waitFrames(1);

        applyStimulus(10, 1'b1);
        waitFrames(3);
        checkOutput("star_valid", 32'(key_valid), 32'd1);
        checkOutput("star_code", 32'(key_code), 32'd10);
        applyStimulus(10, 1'b0);
        waitFrames(3);

        applyStimulus(11, 1'b1);
        waitFrames(3);
        checkOutput("hash_valid", 32'(key_valid), 32'd1);
        checkOutput("hash_code", 32'(key_code), 32'd11);
        applyStimulus(11, 1'b0);
        waitFrames(3);

        $display("[TB] slide 7 to 8");
        applyStimulus(7, 1'b1);
        waitFrames(3);
        checkOutput("k7_valid", 32'(key_valid), 32'd1);
        checkOutput("k7_code", 32'(key_code), 32'd7);
        base = strobes;
        applyStimulus(7, 1'b0);
        applyStimulus(8, 1'b1);
        waitFrames(3);
        checkOutput("slide_strobes", 32'(strobes), 32'(base));
        checkOutput("slide_code", 32'(key_code), 32'd7);
        checkOutput("slide_held", 32'(key_held), 32'd1);
        applyStimulus(8, 1'b0);
        waitFrames(3);
        checkOutput("slide_rel_held", 32'(key_held), 32'd0);
        applyStimulus(8, 1'b1);
        waitFrames(3);
        checkOutput("k8_valid", 32'(key_valid), 32'd1);
        checkOutput("k8_code", 32'(key_code), 32'd8);
        applyStimulus(8, 1'b0);
        waitFrames(3);

        $display("[TB] init during debounce of 3");
        base = strobes;
        applyStimulus(3, 1'b1);
        waitFrames(1);
        waitCycles(12);
        init = 1'b1;
        waitCycles(1);
        checkOutput("init_row", 32'(row), 32'd1);
        checkOutput("init_code", 32'(key_code), 32'd15);
        checkOutput("init_valid", 32'(key_valid), 32'd0);
        checkOutput("init_held", 32'(key_held), 32'd0);
        init = 1'b0;
        waitFrames(2);
        checkOutput("k3_early_strobes", 32'(strobes), 32'(base));
        waitFrames(1);
        checkOutput("k3_valid", 32'(key_valid), 32'd1);
        checkOutput("k3_code", 32'(key_code), 32'd3);
        checkOutput("k3_strobes", 32'(strobes), 32'(base + 1));
        applyStimulus(3, 1'b0);
        waitFrames(3);
        checkOutput("k3_rel_held", 32'(key_held), 32'd0);

        checkOutput("valid_width", 32'(wide_pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream input stage of the safe controller. It drives the one-hot row lines of the 4x3 matrix keypad and samples the column lines through a synchronizer. It resolves each full scan into no key, one key or several keys, and debounces across scans. Each accepted press is delivered to the safe state machine as a single-cycle `key_valid` strobe with a 4-bit `key_code`.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each row is driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results needed to accept a press or a release. Must be ≥ 2.
- `clk`  input  1  system clock; all logic on posedge.
- `init`  input  1  reset: synchronous, active-high.
- `col`  input  3  raw keypad columns, active-high. `col[0]` is the left column; asynchronous to `clk`.
- `row`  output  4  one-hot row drive. `row[0]` is the top row.
- `key_code`  output  4  last accepted key. Values 0–9 are digits, `*` = 10, `#` = 11, 15 = none since reset.
- `key_valid`  output  1  one-cycle strobe when a press is accepted.
- `key_held`  output  1  high from acceptance until the release is debounced.

## Operation
- Key map (row, col) → code:
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: 10, 0, 11
- `col` passes through a 2-flop synchronizer, `col_s`, reset to 0.
- Dwell counter `dwell` runs 0..SCAN_DIV-1.
- The cycle with `dwell == SCAN_DIV-1` is the sample edge:
  - Capture `col_s` for the current row.
  - Advance `row` 0001→0010→0100→1000→0001.
  - Wrap `dwell` to 0.
- Per-row sample classification:
  - 0 bits set → empty.
  - 1 bit set → candidate code.
  - ≥2 bits set → multi.
- Frame accumulator covers rows r0..r3 and is cleared at the start of each frame:
  - Result NONE if all four rows are empty.
  - Result SINGLE(c) if exactly one row holds a candidate and no row is multi.
  - Result MULTI otherwise.
- The frame result is evaluated on the r3 sample edge, which is the frame end.
- Debounce FSM runs once per frame end. `cnt` saturates at DEBOUNCE_SCANS.
  - IDLE:
    - SINGLE(c) → `cand`=c, `cnt`=1, go to DEBOUNCE.
    - Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) → `cnt`++. On reaching DEBOUNCE_SCANS go to PRESSED; `key_code`←cand, `key_valid` pulses, `key_held`=1.
    - SINGLE(other) → `cand`=other, `cnt`=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE, `cnt`=1.
    - Anything else → stay. A new key never fires without a full release; there is no auto-repeat.
  - RELEASE:
    - NONE → `cnt`++. On reaching DEBOUNCE_SCANS go to IDLE, `key_held`=0.
    - Non-NONE → back to PRESSED.
- `key_code` holds its value until the next acceptance. It is not cleared on release.
- `init` asserted at any point (mid-frame, DEBOUNCE, PRESSED) restores every reset value on the next edge. No strobe is produced, and scanning restarts at r0 with `dwell`=0.

## Timing
- Reset values:
  - `row`=0001, `key_code`=15, `key_valid`=0, `key_held`=0.
  - FSM = IDLE; `dwell`, `cnt`, accumulator and synchronizer all = 0.
- Each row is driven for exactly SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- `col` → `col_s` latency is 2 cycles. The level sampled for a row is `col_s` at that row's sample edge.
- `key_valid` and the `key_held` rise are registered. Both are high in the cycle after the accepting frame-end edge; `key_valid` lasts exactly 1 cycle.
- Press latency: a key stable from frame start k is accepted at the end of frame k+DEBOUNCE_SCANS-1.
- Release latency: `key_held` falls at the end of the DEBOUNCE_SCANS-th consecutive NONE frame.
- `init` and a frame end in the same cycle: `init` wins.

## Test plan
Bench settings: SCAN_DIV=8, DEBOUNCE_SCANS=3. The keypad model raises `col[j]` iff a pressed key at (r,j) has `row[r]`=1.
- Reset: hold `init` for 2 cycles → `row`=0001, `key_code`=15, `key_valid`=0, `key_held`=0. After release, `row` steps every 8 cycles: 0010 at cycle 8, 1000 at cycle 24, 0001 at cycle 32.
- Press `5` for 6 frames, then release → exactly one `key_valid` with `key_code`=5 at the end of frame 3. `key_held` is 1 through the press and falls after 3 empty frames; `key_code` stays 5.
- Bounce: `9` present 2 frames, absent 1 frame, present 3 frames → no strobe until the 3rd frame of the second burst, then a single strobe with code 9.
- Multi and specials:
  - `1`+`0` held together for 5 frames → no strobe.
  - `*` alone → code 10.
  - `#` alone → code 11.
- Hold `7` until accepted, then slide to `8` without any empty frame → no second strobe. Release for 3 frames, then press `8` → strobe with code 8.
- Assert `init` for 1 cycle during the 2nd DEBOUNCE frame of `3` → reset values are restored and no strobe is produced. With `3` held afterwards, the strobe arrives 3 full frames after `init` deasserts.
